// File: rtl/or3_mon_pkg.sv
// Shared types and helpers for the OR3 activity monitor: FSM states,
// default widths and the saturating increment used by every counter.
package or3_mon_pkg;

  localparam int unsigned CNT_W_DEF = 16;
  localparam int unsigned WIN_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_DONE
  } mon_state_e;

  // Counters up to 32 bits wide share these helpers; callers cast to their width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic inc,
                                          input int unsigned width);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - width);
    if (inc && (val < max_v)) return val + 32'd1;
    return val;
  endfunction

  function automatic logic sat_hit(input logic [31:0] val, input logic inc,
                                   input int unsigned width);
    logic [31:0] max_v;
    max_v = 32'hFFFF_FFFF >> (32 - width);
    return inc && (val >= max_v);
  endfunction

endpackage

// File: rtl/or3_mon_sync.sv
// Multi-flop synchroniser for one asynchronous bit; SYNC_STAGES must be >= 2.
module or3_mon_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/or3_activity_monitor.sv
// Counts synchronised rise/fall transitions of the OR3 gate output over a
// programmable window. Optional OR3_FUNC_CHECK_EN adds a functional mismatch counter.
module or3_activity_monitor
  import or3_mon_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned WIN_W       = WIN_W_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Q_IN,
  input  logic             START,
  input  logic [WIN_W-1:0] WIN_LEN,
  input  logic             ACK,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
`ifdef OR3_FUNC_CHECK_EN
  input  logic             IN1_OBS,
  input  logic             IN2_OBS,
  input  logic             IN3_OBS,
  output logic [CNT_W-1:0] MISMATCH_CNT,
`endif
  output logic             OVF
);

  localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

  mon_state_e       state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic             ovf_q, ovf_d;
  logic             q_s, prev_q;
  logic             rise, fall;

  or3_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_q (
    .clk_i(CLK), .rst_i(RST), .d_i(Q_IN), .q_o(q_s)
  );

  // prev tracks q_s in every state, which also covers loading it on START.
  always_ff @(posedge CLK) begin
    if (RST) prev_q <= 1'b0;
    else     prev_q <= q_s;
  end

  assign rise = q_s & ~prev_q;
  assign fall = ~q_s & prev_q;

`ifdef OR3_FUNC_CHECK_EN
  logic             in1_s, in2_s, in3_s, mism;
  logic [CNT_W-1:0] mm_q, mm_d;

  or3_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in1 (
    .clk_i(CLK), .rst_i(RST), .d_i(IN1_OBS), .q_o(in1_s)
  );
  or3_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in2 (
    .clk_i(CLK), .rst_i(RST), .d_i(IN2_OBS), .q_o(in2_s)
  );
  or3_mon_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_in3 (
    .clk_i(CLK), .rst_i(RST), .d_i(IN3_OBS), .q_o(in3_s)
  );

  assign mism = q_s != (in1_s | in2_s | in3_s);

  always_ff @(posedge CLK) begin
    if (RST) mm_q <= '0;
    else     mm_q <= mm_d;
  end

  always_comb begin
    mm_d = mm_q;
    if (state_q == ST_IDLE && START)
      mm_d = '0;
    else if (state_q == ST_MEASURE)
      mm_d = CNT_W'(sat_inc(32'(mm_q), mism, CNT_W));
  end

  assign MISMATCH_CNT = mm_q;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      win_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          rise_d = '0;
          fall_d = '0;
          ovf_d  = 1'b0;
          if (WIN_LEN != '0) begin
            win_d   = WIN_LEN;
            state_d = ST_MEASURE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_MEASURE: begin
        rise_d = CNT_W'(sat_inc(32'(rise_q), rise, CNT_W));
        fall_d = CNT_W'(sat_inc(32'(fall_q), fall, CNT_W));
        ovf_d  = ovf_q | sat_hit(32'(rise_q), rise, CNT_W)
                       | sat_hit(32'(fall_q), fall, CNT_W)
`ifdef OR3_FUNC_CHECK_EN
                       | sat_hit(32'(mm_q), mism, CNT_W)
`endif
                       ;
        win_d = win_q - WIN_ONE;
        if (win_q == WIN_ONE) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (ACK) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign BUSY     = (state_q == ST_MEASURE);
  assign DONE     = (state_q == ST_DONE);
  assign RISE_CNT = rise_q;
  assign FALL_CNT = fall_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_or3_activity_monitor.sv
// Randomised + directed bench for or3_activity_monitor against a cycle-level
// behavioural model; define OR3_FUNC_CHECK_EN to also cover the mismatch counter.
module tb_or3_activity_monitor;

  localparam int unsigned S    = 2;
  localparam int unsigned CW   = 4;
  localparam int unsigned WW   = 8;
  localparam int          MAXC = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Q_IN = 1'b0;
  logic          START = 1'b0;
  logic          ACK = 1'b0;
  logic [WW-1:0] WIN_LEN = '0;
  logic          BUSY, DONE, OVF;
  logic [CW-1:0] RISE_CNT, FALL_CNT;
  logic          IN1_OBS = 1'b0, IN2_OBS = 1'b0, IN3_OBS = 1'b0;
`ifdef OR3_FUNC_CHECK_EN
  logic [CW-1:0] MISMATCH_CNT;
`endif

  always #5 CLK = ~CLK;

  or3_activity_monitor #(.SYNC_STAGES(S), .CNT_W(CW), .WIN_W(WW)) dut (
    .CLK(CLK), .RST(RST), .Q_IN(Q_IN), .START(START), .WIN_LEN(WIN_LEN), .ACK(ACK),
    .BUSY(BUSY), .DONE(DONE), .RISE_CNT(RISE_CNT), .FALL_CNT(FALL_CNT),
`ifdef OR3_FUNC_CHECK_EN
    .IN1_OBS(IN1_OBS), .IN2_OBS(IN2_OBS), .IN3_OBS(IN3_OBS), .MISMATCH_CNT(MISMATCH_CNT),
`endif
    .OVF(OVF)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs seen at each clock edge, delayed S cycles to
  // form q_s and S+1 cycles to form prev; phase 0=idle 1=measuring 2=done.
  logic [3:0] hist [0:S];
  int m_phase = 0, m_rem = 0, m_rise = 0, m_fall = 0, m_mm = 0;
  bit m_ovf = 0;
  bit started = 0;

  initial for (int i = 0; i <= S; i++) hist[i] = '0;

  always @(posedge CLK) begin
    logic [3:0] cur, prv;
    bit r, f, mm;
    cur = hist[S-1];
    prv = hist[S];
    r  = cur[0] & ~prv[0];
    f  = ~cur[0] & prv[0];
    mm = cur[0] != (|cur[3:1]);
    if (RST) begin
      m_phase = 0; m_rem = 0; m_rise = 0; m_fall = 0; m_mm = 0; m_ovf = 0;
      for (int i = 0; i <= S; i++) hist[i] = '0;
    end else begin
      if (m_phase == 0) begin
        if (START) begin
          m_rise = 0; m_fall = 0; m_mm = 0; m_ovf = 0;
          if (WIN_LEN == 0) m_phase = 2;
          else begin m_phase = 1; m_rem = WIN_LEN; end
        end
      end else if (m_phase == 1) begin
        if (r) begin if (m_rise == MAXC) m_ovf = 1; else m_rise++; end
        if (f) begin if (m_fall == MAXC) m_ovf = 1; else m_fall++; end
`ifdef OR3_FUNC_CHECK_EN
        if (mm) begin if (m_mm == MAXC) m_ovf = 1; else m_mm++; end
`endif
        m_rem--;
        if (m_rem == 0) m_phase = 2;
      end else begin
        if (ACK) m_phase = 0;
      end
      for (int i = S; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {IN3_OBS, IN2_OBS, IN1_OBS, Q_IN};
    end
    started = 1;
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("busy", 32'(BUSY), 32'(m_phase == 1));
      chk("done", 32'(DONE), 32'(m_phase == 2));
      chk("rise_cnt", 32'(RISE_CNT), 32'(m_rise));
      chk("fall_cnt", 32'(FALL_CNT), 32'(m_fall));
      chk("ovf", 32'(OVF), 32'(m_ovf));
`ifdef OR3_FUNC_CHECK_EN
      chk("mismatch_cnt", 32'(MISMATCH_CNT), 32'(m_mm));
`endif
    end
  end

  task automatic wait_done(input int budget);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (DONE !== 1'b1) chk("done_timeout", 32'(DONE), 32'd1);
  endtask

  task automatic pulse_ack();
    ACK = 1'b1;
    @(negedge CLK);
    ACK = 1'b0;
  endtask

  task automatic start_win(input int len);
    WIN_LEN = WW'(len);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    chk("reset_busy", 32'(BUSY), 32'd0);
    chk("reset_done", 32'(DONE), 32'd0);
    chk("reset_rise", 32'(RISE_CNT), 32'd0);
    repeat (4) @(negedge CLK);

    // Toggle every 4 cycles over a 20-cycle window, with stray STARTs
    start_win(20);
    for (int i = 0; i < 24; i++) begin
      if (i % 4 == 0) Q_IN = ~Q_IN;
      START = (i == 10 || i == 22);
      @(negedge CLK);
    end
    START = 1'b0;
    chk("toggle_done", 32'(DONE), 32'd1);
    chk("toggle_rise", 32'(RISE_CNT), 32'd3);
    chk("toggle_fall", 32'(FALL_CNT), 32'd2);
    pulse_ack();
    chk("ack_idle_done", 32'(DONE), 32'd0);
    chk("ack_held_rise", 32'(RISE_CNT), 32'd3);
    chk("ack_held_fall", 32'(FALL_CNT), 32'd2);

    // Zero-length window, then START+ACK together
    start_win(0);
    chk("zero_done", 32'(DONE), 32'd1);
    chk("zero_busy", 32'(BUSY), 32'd0);
    chk("zero_rise", 32'(RISE_CNT), 32'd0);
    START = 1'b1; ACK = 1'b1; WIN_LEN = 8'd5;
    @(negedge CLK);
    START = 1'b0; ACK = 1'b0;
    chk("startack_done", 32'(DONE), 32'd0);
    @(negedge CLK);
    chk("startack_busy", 32'(BUSY), 32'd0);

    // Saturation
    start_win(64);
    for (int i = 0; i < 70; i++) begin
      Q_IN = ~Q_IN;
      @(negedge CLK);
    end
    wait_done(20);
    chk("sat_rise", 32'(RISE_CNT), 32'd15);
    chk("sat_fall", 32'(FALL_CNT), 32'd15);
    chk("sat_ovf", 32'(OVF), 32'd1);
    pulse_ack();
    repeat (4) @(negedge CLK);
    start_win(5);
    wait_done(20);
    chk("quiet_ovf", 32'(OVF), 32'd0);
    chk("quiet_rise", 32'(RISE_CNT), 32'd0);
    pulse_ack();

    // Reset in the middle of a window
    start_win(30);
    for (int i = 0; i < 8; i++) begin
      Q_IN = ~Q_IN;
      @(negedge CLK);
    end
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_rise", 32'(RISE_CNT), 32'd0);
    chk("midrst_ovf", 32'(OVF), 32'd0);

`ifdef OR3_FUNC_CHECK_EN
    IN1_OBS = 1'b1; Q_IN = 1'b0;
    repeat (4) @(negedge CLK);
    start_win(6);
    wait_done(20);
    chk("mm_six", 32'(MISMATCH_CNT), 32'd6);
    pulse_ack();
    IN1_OBS = 1'b0;
    repeat (4) @(negedge CLK);
    start_win(50);
    for (int i = 0; i < 50; i++) begin
      {IN3_OBS, IN2_OBS, IN1_OBS} = 3'($urandom);
      Q_IN = IN1_OBS | IN2_OBS | IN3_OBS;
      @(negedge CLK);
    end
    wait_done(20);
    chk("mm_zero", 32'(MISMATCH_CNT), 32'd0);
    pulse_ack();
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      RST     = ($urandom_range(0, 99) == 0);
      START   = ($urandom_range(0, 5) == 0);
      WIN_LEN = WW'($urandom_range(0, 24));
      ACK     = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) Q_IN = ~Q_IN;
`ifdef OR3_FUNC_CHECK_EN
      {IN3_OBS, IN2_OBS, IN1_OBS} = 3'($urandom);
      Q_IN = (IN1_OBS | IN2_OBS | IN3_OBS) ^ ($urandom_range(0, 4) == 0);
`endif
      @(negedge CLK);
    end
    RST = 1'b0; START = 1'b0; ACK = 1'b0;
    repeat (3) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/or3_activity_monitor.md
Name: or3_activity_monitor

Overview:
- Downstream observation stage for the 3-input OR gate under power test. Synchronises the gate output, then counts rising and falling transitions over a programmable window of clock cycles.
- Reports the counts with a done/ack handshake, so the power bench can correlate measured current with switching activity.
- Sits between the gate-under-test netlist and the bench controller/scan-out logic.

Parameters:
- SYNC_STAGES, 2, synchroniser flops on Q_IN (minimum 2).
- CNT_W, 16, width of each transition counter.
- WIN_W, 16, width of the window-length input and internal window counter.

Ports:
- CLK  input  1  single clock.
- RST  input  1  reset; the synchronous and active-high polarity is fixed.
- Q_IN  input  1  asynchronous output of the OR gate under test.
- START  input  1  single-cycle request to begin a measurement window.
- WIN_LEN  input  WIN_W  window length in cycles, sampled on the accepted START.
- ACK  input  1  bench acknowledges the result; returns the block to IDLE.
- BUSY  output  1  high in MEASURE.
- DONE  output  1  high in DONE; result valid.
- RISE_CNT  output  CNT_W  rising transitions counted in the window.
- FALL_CNT  output  CNT_W  falling transitions counted in the window.
- OVF  output  1  sticky; set when either counter saturates.

Behaviour:
- Reset: when RST=1 at a CLK edge, the following are cleared:
  - state goes to IDLE
  - BUSY, DONE, OVF, RISE_CNT, FALL_CNT all go to 0
  - synchroniser flops, prev-sample flop and window counter go to 0
- Reset mid-window aborts the measurement; there is no partial result.
- Synchroniser: Q_IN passes through SYNC_STAGES flops to give q_s; prev holds q_s from the previous cycle.
  - Edge detection: rise = q_s & ~prev; fall = ~q_s & prev.
  - Latency from a Q_IN change to the counter update is SYNC_STAGES+1 cycles.
- FSM states: IDLE, MEASURE, DONE.
- IDLE:
  - START=1 with WIN_LEN!=0: clear RISE_CNT, FALL_CNT and OVF, load the window counter with WIN_LEN, load prev with q_s, and go to MEASURE.
  - START=1 with WIN_LEN=0: clear the counters and go directly to DONE.
- MEASURE:
  - Each cycle, add rise to RISE_CNT and fall to FALL_CNT, then decrement the window counter.
  - When the window counter is 1, this is the last sampled cycle; the next state is DONE.
  - Exactly WIN_LEN cycles are sampled.
  - Counters saturate at 2^CNT_W-1; an increment attempted at saturation sets OVF, and OVF stays set until the next accepted START.
- DONE:
  - DONE=1; counts and OVF are held.
  - ACK=1 goes to IDLE next cycle; DONE drops and the counts stay visible until the next START.
- START is ignored in MEASURE and DONE. START and ACK together in DONE: ACK wins and START is dropped; the bench must re-issue START in IDLE.
- ACK is ignored outside DONE.
- Edges are counted only in MEASURE; q_s/prev keep tracking in all states.

Optional Feature:
- Macro: OR3_FUNC_CHECK_EN.
- When defined:
  - Adds ports IN1_OBS, IN2_OBS, IN3_OBS (input, 1 each) and MISMATCH_CNT (output, CNT_W).
  - The three inputs are synchronised with the same depth as Q_IN.
  - In MEASURE, each cycle where q_s != (in1_s | in2_s | in3_s) increments MISMATCH_CNT.
  - MISMATCH_CNT saturates, contributes to OVF, is cleared on accepted START and by reset, and is held in DONE.
- When undefined: these ports and the associated logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package or3_mon_pkg holds:
  - the state enum (IDLE/MEASURE/DONE)
  - default CNT_W/WIN_W localparams
  - a saturating-increment function used by all counters
- Sub-module: or3_mon_sync, a parameterised SYNC_STAGES bit synchroniser, instantiated for Q_IN and, with OR3_FUNC_CHECK_EN, for each IN*_OBS.

Test Plan:
- Reset behaviour: RST high for 3 cycles during MEASURE -> BUSY=0, DONE=0, counts=0 and OVF=0 on the cycle after release; a later START runs normally.
- Toggle counting: WIN_LEN=20, Q_IN toggled every 4 cycles starting after START -> DONE after 20 MEASURE cycles, RISE_CNT+FALL_CNT=5, with counts differing by at most 1.
- Zero window: WIN_LEN=0, START -> DONE=1 on the next cycle, RISE_CNT=FALL_CNT=0, BUSY never asserted.
- Saturation: CNT_W=4, Q_IN toggled every cycle with WIN_LEN=64 -> RISE_CNT=FALL_CNT=15 and OVF=1; the next START with a quiet input clears OVF.
- Handshake edges:
  - START pulsed during MEASURE and DONE -> ignored.
  - START+ACK together in DONE -> IDLE with no new window.
  - ACK alone -> IDLE, with counts held.
- With OR3_FUNC_CHECK_EN: drive IN1_OBS=1 and force Q_IN=0 for 6 window cycles -> MISMATCH_CNT=6; a consistent OR pattern over 50 cycles -> MISMATCH_CNT=0.
